clk_div_monitor: RTL
====================

Name: clk_div_monitor

Overview:
- Consumes the divided clock produced by the even clock divider and measures it in clkin cycles: period and high time of each cycle.
- Declares lock after LOCK_CNT consecutive periods match the expected values.
- Flags mismatch after lock and flags a stuck divided clock (timeout).
- Sits directly downstream of the divider as its self-check/health monitor. All logic is in the clkin domain.

Parameters:
- CNT_W, 8, width of measurement counters and outputs.
- EXP_PERIOD, 6, expected period in clkin cycles.
- EXP_HIGH, 3, expected high time in clkin cycles.
- LOCK_CNT, 4, consecutive matching periods required for lock (1..15).
- TIMEOUT, 12, clkin cycles without a rising edge that declare stuck. Must satisfy EXP_PERIOD < TIMEOUT < 2^CNT_W-1.

Ports:
- clkin  input  1  system clock, sole clock; same clock that drives the divider.
- rst  input  1  reset, asynchronous, active-high.
- div_clk  input  1  divided clock under test, sampled as data.
- clr_err  input  1  one-cycle pulse, clears err.
- period_o  output  CNT_W  last measured period, rise to rise.
- high_o  output  CNT_W  last measured high time.
- meas_valid  output  1  one-cycle pulse; period_o/high_o updated.
- locked  output  1  high while state == LOCKED.
- err  output  1  sticky; mismatch or stuck seen while LOCKED.
- stuck  output  1  one-cycle pulse on timeout.

Behaviour:
- Interface: one clock, clkin. Reset rst is asynchronous and active-high. On reset all registers go to 0: state IDLE, counters 0, all outputs 0.
- Input stage:
  - 2-flop synchronizer s1, s2, plus delayed copy s3.
  - rise = s2 & ~s3.
  - Fixed 2-cycle detect latency; does not affect measured values.
- Counters:
  - pcnt: on rise, load 1; otherwise increment, saturating at 2^CNT_W-1.
  - hcnt: on rise, load 1; else if s2, increment (saturating); else hold.
- Capture (ACQ/LOCKED only), at a clock edge with rise=1:
  - period_o <= pcnt, high_o <= hcnt, meas_valid <= 1 for one cycle.
  - Example: div6 with 3 high gives period_o=6, high_o=3.
- match = (pcnt == EXP_PERIOD) && (hcnt == EXP_HIGH), evaluated at a rise.
- FSM, states IDLE, ACQ, LOCKED:
  - IDLE: counters idle. On rise: load counters, go to ACQ, mcnt=0, no meas_valid (first edge gives no complete period).
  - ACQ, on rise:
    - If match: mcnt++. When mcnt reaches LOCK_CNT, go to LOCKED; locked=1 in the same cycle meas_valid pulses.
    - If mismatch: mcnt=0, stay in ACQ.
  - LOCKED, on rise with mismatch: go to ACQ, mcnt=0, err<=1, locked<=0. A match stays in LOCKED.
  - ACQ/LOCKED, when pcnt == TIMEOUT with no rise in that cycle: go to IDLE, stuck pulses one cycle. err<=1 only if coming from LOCKED.
- Boundary conditions:
  - Rise coincides with pcnt==TIMEOUT: the rise wins; measurement taken, no stuck.
  - clr_err in the same cycle as a new error: err stays 1 (set dominates).
  - clr_err with no error: err<=0.
  - Reset mid-measurement: immediate return to IDLE. The first rise after reset never produces meas_valid.
  - div_clk constant from reset: stays in IDLE forever. No stuck in IDLE; stuck requires at least one prior rise.

Decomposition:
- Package clk_div_pkg holds:
  - state encodings IDLE=2'd0, ACQ=2'd1, LOCKED=2'd2;
  - default CNT_W, EXP_PERIOD, EXP_HIGH (shared with the divider's num/fen values).
- One sub-module: sync_edge_det, containing the 2-flop synchronizer, delay flop and rise output, with clkin/rst. The FSM and counters stay in the top module.

Test Plan:
- Nominal divider num=6 after reset:
  - First rise gives no meas_valid.
  - Next rises give meas_valid with period_o=6, high_o=3.
  - locked=1 coincident with the 4th valid measurement; err=0.
- Locked, then one period stretched to 7 (high 4):
  - meas_valid with period_o=7, high_o=4; locked->0, err->1.
  - After 4 good periods locked=1 again, err still 1.
  - clr_err pulse then clears err.
- Locked, then div_clk held low: stuck pulses exactly when pcnt==12, state goes to IDLE, locked=0, err=1.
- clr_err asserted in the same cycle as a LOCKED mismatch: err remains 1.
- Duty 2/6 (period 6, high 2) from reset: meas_valid with high_o=2, locked never asserts, err stays 0.
- rst pulsed mid-period while LOCKED:
  - All outputs go to 0 immediately, asynchronously.
  - Relock needs 1 + LOCK_CNT further rises.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the even clock divider and its health monitor.
package clk_div_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } mon_state_e;

  // Defaults shared with the divider's num/fen settings
  localparam int CNT_W_DEF      = 8;
  localparam int EXP_PERIOD_DEF = 6;
  localparam int EXP_HIGH_DEF   = 3;

endpackage

// File: rtl/clk_div_monitor_sync_edge_det.sv
// Brings the divided clock into the clkin domain as data and flags its rising edges.
module sync_edge_det (
  input  logic clkin,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two-flop synchronizer plus one delay stage used for edge detection
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of the divided clock in clkin cycles, tracks
// lock against the expected shape, and reports mismatches and a stuck clock.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PERIOD = EXP_PERIOD_DEF,
  parameter int EXP_HIGH   = EXP_HIGH_DEF,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 12
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_EXP  = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] HIGH_EXP = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_VAL = 4'(LOCK_CNT);

  mon_state_e       state_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [3:0]       mcnt_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             meas_valid_q;
  logic             locked_q;
  logic             err_q;
  logic             stuck_q;

  logic divLevel;
  logic rise;
  logic match;
  logic timeoutHit;

  sync_edge_det u_sync (
    .clkin   (clkin),
    .rst     (rst),
    .d_i     (div_clk),
    .level_o (divLevel),
    .rise_o  (rise)
  );

  assign match      = (pcnt_q == PER_EXP) && (hcnt_q == HIGH_EXP);
  assign timeoutHit = (state_q != IDLE) && !rise && (pcnt_q == TO_VAL);

  // Next-state of the measurement counters: reload on a rise, saturate while counting
  always_comb begin
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    if (rise) begin
      pcnt_d = CNT_ONE;
      hcnt_d = CNT_ONE;
    end else if (state_q == IDLE) begin
      pcnt_d = pcnt_q;
      hcnt_d = hcnt_q;
    end else if (timeoutHit) begin
      pcnt_d = '0;
      hcnt_d = '0;
    end else begin
      pcnt_d = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + CNT_ONE;
      if (divLevel) begin
        hcnt_d = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CNT_ONE;
      end
    end
  end

  // Measurement counter registers
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      hcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  // Lock FSM with registered outputs; a new error overrides a clear in the same cycle
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mcnt_q       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      stuck_q      <= 1'b0;
      if (clr_err) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= ACQ;
            mcnt_q  <= '0;
          end
        end
        ACQ: begin
          if (rise) begin
            period_q     <= pcnt_q;
            high_q       <= hcnt_q;
            meas_valid_q <= 1'b1;
            if (match) begin
              if (mcnt_q + 4'd1 == LOCK_VAL) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                mcnt_q   <= '0;
              end else begin
                mcnt_q <= mcnt_q + 4'd1;
              end
            end else begin
              mcnt_q <= '0;
            end
          end else if (timeoutHit) begin
            state_q <= IDLE;
            stuck_q <= 1'b1;
            mcnt_q  <= '0;
          end
        end
        LOCKED: begin
          if (rise) begin
            period_q     <= pcnt_q;
            high_q       <= hcnt_q;
            meas_valid_q <= 1'b1;
            if (!match) begin
              state_q  <= ACQ;
              mcnt_q   <= '0;
              err_q    <= 1'b1;
              locked_q <= 1'b0;
            end
          end else if (timeoutHit) begin
            state_q  <= IDLE;
            stuck_q  <= 1'b1;
            err_q    <= 1'b1;
            locked_q <= 1'b0;
            mcnt_q   <= '0;
          end
        end
        default: begin
          state_q  <= IDLE;
          locked_q <= 1'b0;
          mcnt_q   <= '0;
        end
      endcase
    end
  end

  assign period_o   = period_q;
  assign high_o     = high_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign stuck      = stuck_q;

endmodule
